// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the shared byte transmitter arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the uart_tx instance.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 locked;
  logic                 tx_byte_rdy;
  logic [7:0]           tx_byte;
  logic                 tx_busy;
  logic                 timeout;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, locked, tx_byte_rdy, tx_byte, timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, locked, tx_byte_rdy, tx_byte, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between NUM_REQ requesters.
// A granted requester keeps the transmitter until the byte it sends is flagged last.
//
// state     | meaning
// ARB       | pick owner (round-robin, or the locked owner); idle while uart still busy
// ISSUE     | accept owner byte (req_ready), load tx_byte, raise tx_byte_rdy
// WAIT_BUSY | hold tx_byte_rdy until uart reports busy; down-counter bounds the wait
// WAIT_DONE | wait for uart busy to fall; release grant if the frame ended
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state, state_d;
  logic [NUM_REQ-1:0] grant, grant_d;
  logic [PW-1:0]      owner, owner_d;
  logic [PW-1:0]      ptr, ptr_d;
  logic               locked, locked_d;
  logic               tx_byte_rdy, tx_byte_rdy_d;
  logic [7:0]         tx_byte, tx_byte_d;
  logic               timeout, timeout_d;
  logic [CW-1:0]      cnt, cnt_d;

  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      cand;

  // First valid requester after the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state;
    grant_d       = grant;
    owner_d       = owner;
    ptr_d         = ptr;
    locked_d      = locked;
    tx_byte_rdy_d = tx_byte_rdy;
    tx_byte_d     = tx_byte;
    timeout_d     = 1'b0;
    cnt_d         = cnt;
    case (state)
      ARB: begin
        // Gating on busy covers a reset that landed mid-byte.
        if (!bus.tx_busy) begin
          if (locked) begin
            if (bus.req_valid[owner]) state_d = ISSUE;
          end else if (win_found) begin
            grant_d = NUM_REQ'(1) << win_idx;
            owner_d = win_idx;
            ptr_d   = win_idx;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        tx_byte_d     = bus.req_data[{owner, 3'b000} +: 8];
        tx_byte_rdy_d = 1'b1;
        locked_d      = ~bus.req_last[owner];
        cnt_d         = CW'(BUSY_TIMEOUT - 1);
        state_d       = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          tx_byte_rdy_d = 1'b0;
          cnt_d         = '0;
          state_d       = WAIT_DONE;
        end else if (cnt == '0) begin
          tx_byte_rdy_d = 1'b0;
          timeout_d     = 1'b1;
          locked_d      = 1'b0;
          grant_d       = '0;
          state_d       = ARB;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = ARB;
          if (!locked) grant_d = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB;
      grant       <= '0;
      owner       <= '0;
      ptr         <= PW'(NUM_REQ - 1);
      locked      <= 1'b0;
      tx_byte_rdy <= 1'b0;
      tx_byte     <= '0;
      timeout     <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      owner       <= owner_d;
      ptr         <= ptr_d;
      locked      <= locked_d;
      tx_byte_rdy <= tx_byte_rdy_d;
      tx_byte     <= tx_byte_d;
      timeout     <= timeout_d;
      cnt         <= cnt_d;
    end
  end

  assign bus.req_ready   = (state == ISSUE) ? grant : '0;
  assign bus.grant       = grant;
  assign bus.locked      = locked;
  assign bus.tx_byte_rdy = tx_byte_rdy;
  assign bus.tx_byte     = tx_byte;
  assign bus.timeout     = timeout;

endmodule
